// File: rtl/hs_host_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : hs_host_regs_if
// Brief    : Host register bus bundle. The host side drives strobes, address
//            and write data. The register file side returns a registered ack
//            and read data.
// Revision : 1.0 - initial release
// ============================================================================
interface hs_host_regs_if #(
  parameter int C_ADDR_W = 6
);
  logic                reg_wr;
  logic                reg_rd;
  logic [C_ADDR_W-1:0] reg_addr;
  logic [31:0]         reg_wdata;
  logic [31:0]         reg_rdata;
  logic                reg_ack;

  modport master (
    output reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );
endinterface
`default_nettype wire

// File: rtl/hs_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : hs_host_regs
// Brief    : Host register file and ring controller for the SATA mailbox.
//            It holds the ring bases, pointer addresses and indices. It tracks
//            index movement in STATUS and raises an interrupt from it. It also
//            runs the per-channel error request/ack handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module hs_host_regs #(
  parameter int C_NUM_CH = 4,
  parameter int C_IDX_W  = 12,
  parameter int C_ERR_W  = 8,
  parameter int C_ADDR_W = 6
) (
  input  wire logic                      sys_clk,
  input  wire logic                      sys_rst,
  hs_host_regs_if.slave                  bus,
  output logic [31:0]                    outband_base,
  output logic [31:0]                    outband_prod_addr,
  output logic [C_IDX_W-1:0]             outband_cons_index,
  input  wire logic [C_IDX_W-1:0]        outband_prod_index,
  output logic [31:0]                    inband_base,
  output logic [31:0]                    inband_cons_addr,
  output logic [C_IDX_W-1:0]             inband_prod_index,
  input  wire logic [C_IDX_W-1:0]        inband_cons_index,
  output logic                           ring_enable,
  output logic                           DBG_STOP,
  output logic                           irq,
  output logic [C_NUM_CH*C_ERR_W-1:0]    err_req,
  input  wire logic [C_NUM_CH*C_ERR_W-1:0] err_ack,
  input  wire logic [C_NUM_CH*32-1:0]    dma_state
);

  localparam int GRP_W = C_ADDR_W - 3;

  localparam logic [C_ADDR_W-1:0] A_CTRL          = C_ADDR_W'(8'h00);
  localparam logic [C_ADDR_W-1:0] A_STATUS        = C_ADDR_W'(8'h01);
  localparam logic [C_ADDR_W-1:0] A_OUT_BASE      = C_ADDR_W'(8'h02);
  localparam logic [C_ADDR_W-1:0] A_OUT_PROD_ADDR = C_ADDR_W'(8'h03);
  localparam logic [C_ADDR_W-1:0] A_OUT_CONS_IDX  = C_ADDR_W'(8'h04);
  localparam logic [C_ADDR_W-1:0] A_OUT_PROD_IDX  = C_ADDR_W'(8'h05);
  localparam logic [C_ADDR_W-1:0] A_IN_BASE       = C_ADDR_W'(8'h06);
  localparam logic [C_ADDR_W-1:0] A_IN_CONS_ADDR  = C_ADDR_W'(8'h07);
  localparam logic [C_ADDR_W-1:0] A_IN_PROD_IDX   = C_ADDR_W'(8'h08);
  localparam logic [C_ADDR_W-1:0] A_IN_CONS_IDX   = C_ADDR_W'(8'h09);
  localparam logic [C_ADDR_W-1:0] A_OCC           = C_ADDR_W'(8'h0A);

  // Per-channel blocks occupy 8-word groups, selected by addr[msb:3].
  localparam logic [GRP_W-1:0] G_ERR_REQ  = GRP_W'(2);
  localparam logic [GRP_W-1:0] G_ERR_DONE = GRP_W'(3);
  localparam logic [GRP_W-1:0] G_DMA      = GRP_W'(4);

  logic                        wr_en;
  logic                        rd_en;
  logic [GRP_W-1:0]            grp;
  logic [2:0]                  ch;
  logic                        irq_en;
  logic [1:0]                  status;
  logic [1:0]                  status_set;
  logic [1:0]                  status_clr;
  logic                        ring_disable;
  logic [C_IDX_W-1:0]          out_prod_shadow;
  logic [C_IDX_W-1:0]          in_cons_shadow;
  logic [C_IDX_W-1:0]          out_occ;
  logic [C_IDX_W-1:0]          in_occ;
  logic [C_NUM_CH*C_ERR_W-1:0] req_q;
  logic [C_NUM_CH*C_ERR_W-1:0] done_q;
  logic [C_NUM_CH*C_ERR_W-1:0] req_set;
  logic [C_NUM_CH*C_ERR_W-1:0] done_clr;
  logic [C_NUM_CH*C_ERR_W-1:0] eff_ack;
  logic [31:0]                 rd_mux;

  // A simultaneous read and write is handled as a write only.
  assign wr_en = bus.reg_wr;
  assign rd_en = bus.reg_rd & ~bus.reg_wr;
  assign grp   = bus.reg_addr[C_ADDR_W-1:3];
  assign ch    = bus.reg_addr[2:0];

  // A CTRL write that drops ring_enable clears the ring state on that same edge.
  assign ring_disable = wr_en && (bus.reg_addr == A_CTRL) && ring_enable && !bus.reg_wdata[0];

  assign status_set = ring_enable ? {inband_cons_index != in_cons_shadow,
                                     outband_prod_index != out_prod_shadow} : 2'b00;
  assign status_clr = (wr_en && (bus.reg_addr == A_STATUS)) ? bus.reg_wdata[1:0] : 2'b00;

  assign out_occ = outband_prod_index - outband_cons_index;
  assign in_occ  = inband_prod_index - inband_cons_index;

  // An ack only counts against a bit that is currently requested.
  assign eff_ack = err_ack & req_q;
  assign err_req = req_q;

  // Decode host writes into the per-channel request-set and done-clear masks.
  always_comb begin
    req_set  = '0;
    done_clr = '0;
    for (int n = 0; n < C_NUM_CH; n++) begin
      if (wr_en && (ch == 3'(n)) && (grp == G_ERR_REQ))
        req_set[n*C_ERR_W +: C_ERR_W] = bus.reg_wdata[C_ERR_W-1:0];
      if (wr_en && (ch == 3'(n)) && (grp == G_ERR_DONE))
        done_clr[n*C_ERR_W +: C_ERR_W] = bus.reg_wdata[C_ERR_W-1:0];
    end
  end

  // Control and ring registers, index shadows, STATUS and the interrupt.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ring_enable        <= 1'b0;
      DBG_STOP           <= 1'b0;
      irq_en             <= 1'b0;
      irq                <= 1'b0;
      status             <= 2'b00;
      out_prod_shadow    <= '0;
      in_cons_shadow     <= '0;
      outband_base       <= '0;
      outband_prod_addr  <= '0;
      outband_cons_index <= '0;
      inband_base        <= '0;
      inband_cons_addr   <= '0;
      inband_prod_index  <= '0;
    end else begin
      out_prod_shadow <= outband_prod_index;
      in_cons_shadow  <= inband_cons_index;
      irq             <= irq_en & (|status);
      if (wr_en) begin
        case (bus.reg_addr)
          A_CTRL: begin
            ring_enable <= bus.reg_wdata[0];
            DBG_STOP    <= bus.reg_wdata[1];
            irq_en      <= bus.reg_wdata[2];
          end
          A_OUT_BASE:      outband_base       <= bus.reg_wdata;
          A_OUT_PROD_ADDR: outband_prod_addr  <= bus.reg_wdata;
          A_OUT_CONS_IDX:  outband_cons_index <= bus.reg_wdata[C_IDX_W-1:0];
          A_IN_BASE:       inband_base        <= bus.reg_wdata;
          A_IN_CONS_ADDR:  inband_cons_addr   <= bus.reg_wdata;
          A_IN_PROD_IDX:   inband_prod_index  <= bus.reg_wdata[C_IDX_W-1:0];
          default: ;
        endcase
      end
      // Ring disable wins over everything. A new movement wins over W1C.
      if (ring_disable) begin
        outband_cons_index <= '0;
        inband_prod_index  <= '0;
        status             <= 2'b00;
      end else begin
        status <= (status & ~status_clr) | status_set;
      end
    end
  end

  // Error handshake: an ack retires the request and records it as done.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req_q  <= '0;
      done_q <= '0;
    end else begin
      req_q  <= (req_q & ~eff_ack) | req_set;
      done_q <= (done_q & ~done_clr) | eff_ack;
    end
  end

  // Read multiplexer. Any unmapped address reads as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      A_CTRL:          rd_mux = {29'b0, irq_en, DBG_STOP, ring_enable};
      A_STATUS:        rd_mux = {30'b0, status};
      A_OUT_BASE:      rd_mux = outband_base;
      A_OUT_PROD_ADDR: rd_mux = outband_prod_addr;
      A_OUT_CONS_IDX:  rd_mux = 32'(outband_cons_index);
      A_OUT_PROD_IDX:  rd_mux = 32'(outband_prod_index);
      A_IN_BASE:       rd_mux = inband_base;
      A_IN_CONS_ADDR:  rd_mux = inband_cons_addr;
      A_IN_PROD_IDX:   rd_mux = 32'(inband_prod_index);
      A_IN_CONS_IDX:   rd_mux = 32'(inband_cons_index);
      A_OCC:           rd_mux = {16'(in_occ), 16'(out_occ)};
      default: ;
    endcase
    for (int n = 0; n < C_NUM_CH; n++) begin
      if (ch == 3'(n)) begin
        if (grp == G_ERR_REQ)  rd_mux = 32'(req_q[n*C_ERR_W +: C_ERR_W]);
        if (grp == G_ERR_DONE) rd_mux = 32'(done_q[n*C_ERR_W +: C_ERR_W]);
        if (grp == G_DMA)      rd_mux = dma_state[n*32 +: 32];
      end
    end
  end

  // Registered bus response: one ack per strobe, data only for pure reads.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.reg_ack   <= 1'b0;
      bus.reg_rdata <= '0;
    end else begin
      bus.reg_ack   <= bus.reg_wr | bus.reg_rd;
      bus.reg_rdata <= rd_en ? rd_mux : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_host_regs
// Brief    : Directed self-checking bench for hs_host_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_host_regs;
  localparam int NUM_CH = 4;
  localparam int IDX_W  = 12;
  localparam int ERR_W  = 8;
  localparam int ADDR_W = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [31:0]             outband_base, outband_prod_addr, inband_base, inband_cons_addr;
  logic [IDX_W-1:0]        outband_cons_index, outband_prod_index;
  logic [IDX_W-1:0]        inband_prod_index, inband_cons_index;
  logic                    ring_enable, dbg_stop, irq;
  logic [NUM_CH*ERR_W-1:0] err_req, err_ack;
  logic [NUM_CH*32-1:0]    dma_state;
  logic [31:0]             rv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hs_host_regs_if #(.C_ADDR_W(ADDR_W)) bus ();

  hs_host_regs #(
    .C_NUM_CH(NUM_CH), .C_IDX_W(IDX_W), .C_ERR_W(ERR_W), .C_ADDR_W(ADDR_W)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .bus(bus),
    .outband_base(outband_base), .outband_prod_addr(outband_prod_addr),
    .outband_cons_index(outband_cons_index), .outband_prod_index(outband_prod_index),
    .inband_base(inband_base), .inband_cons_addr(inband_cons_addr),
    .inband_prod_index(inband_prod_index), .inband_cons_index(inband_cons_index),
    .ring_enable(ring_enable), .DBG_STOP(dbg_stop), .irq(irq),
    .err_req(err_req), .err_ack(err_ack), .dma_state(dma_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic reg_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr = 1'b0;
    chk("wr_ack", 32'(bus.reg_ack), 32'd1);
  endtask

  task automatic reg_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    bus.reg_rd = 1'b1; bus.reg_addr = a;
    @(negedge clk);
    bus.reg_rd = 1'b0;
    chk("rd_ack", 32'(bus.reg_ack), 32'd1);
    d = bus.reg_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    outband_prod_index = '0; inband_cons_index = '0; err_ack = '0;
    dma_state = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.reg_ack), 32'd0);
    chk("rst_rdata", bus.reg_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ctrl_outs", {29'b0, ring_enable, dbg_stop, irq}, 32'd0);
    chk("rst_out_base", outband_base | outband_prod_addr, 32'd0);
    chk("rst_in_base", inband_base | inband_cons_addr, 32'd0);
    chk("rst_idx", {8'b0, outband_cons_index, inband_prod_index}, 32'd0);
    chk("rst_err_req", err_req, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Every register in the low map reads zero after reset.
    for (int a = 0; a <= 10; a++) rd_chk($sformatf("rst_read_%0d", a), ADDR_W'(a), 32'd0);

    // Index movement sets STATUS and then irq; W1C drops irq.
    reg_write(6'h00, 32'd5);
    chk("ctrl_ring_en", 32'(ring_enable), 32'd1);
    chk("ctrl_dbg", 32'(dbg_stop), 32'd0);
    outband_prod_index = 12'd3;
    @(negedge clk);
    chk("irq_lat1", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_lat2", 32'(irq), 32'd1);
    rd_chk("status_out_moved", 6'h01, 32'd1);
    rd_chk("out_prod_idx", 6'h05, 32'd3);
    reg_write(6'h01, 32'd1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("status_cleared", 6'h01, 32'd0);

    // Occupancy wraps modulo 2**IDX_W; index writes keep the low bits.
    reg_write(6'h02, 32'hA5A5_0001);
    chk("out_base_port", outband_base, 32'hA5A5_0001);
    rd_chk("out_base_rd", 6'h02, 32'hA5A5_0001);
    reg_write(6'h04, 32'h0000_0FFE);
    outband_prod_index = 12'h002;
    inband_cons_index  = 12'h001;
    rd_chk("occ_wrap", 6'h0A, 32'h0FFF_0004);
    reg_write(6'h04, 32'h0000_1234);
    rd_chk("cons_idx_trunc", 6'h04, 32'h0000_0234);
    chk("cons_idx_port", 32'(outband_cons_index), 32'h234);
    rd_chk("in_cons_idx", 6'h09, 32'd1);

    // Error handshake on channel 2.
    reg_write(6'h12, 32'h81);
    chk("err_req_set", 32'(err_req[23:16]), 32'h81);
    err_ack = 32'h0001_0000;
    @(negedge clk);
    err_ack = '0;
    chk("err_req_after_ack", 32'(err_req[23:16]), 32'h80);
    rd_chk("err_req_rd", 6'h12, 32'h80);
    rd_chk("err_done_rd", 6'h1A, 32'h01);
    bus.reg_wr = 1'b1; bus.reg_addr = 6'h12; bus.reg_wdata = 32'h80;
    err_ack = 32'h0080_0000;
    @(negedge clk);
    bus.reg_wr = 1'b0; err_ack = '0;
    chk("set_ack_same_ack", 32'(bus.reg_ack), 32'd1);
    chk("set_ack_same_req", 32'(err_req[23:16]), 32'h80);
    rd_chk("set_ack_same_done", 6'h1A, 32'h81);
    reg_write(6'h1A, 32'h01);
    rd_chk("done_w1c", 6'h1A, 32'h80);
    err_ack = 32'h0008_0000;
    @(negedge clk);
    err_ack = '0;
    rd_chk("stray_ack_done", 6'h1A, 32'h80);
    chk("stray_ack_req", 32'(err_req[23:16]), 32'h80);
    reg_write(6'h14, 32'hFF);
    rd_chk("err_ch4_unmapped", 6'h14, 32'd0);
    chk("err_req_untouched", err_req, 32'h0080_0000);

    // DMA state readback and the unmapped fifth channel.
    rd_chk("dma_ch1", 6'h21, 32'hDEAD_BEEF);
    rd_chk("dma_ch3", 6'h23, 32'h4444_4444);
    rd_chk("dma_ch4", 6'h24, 32'd0);
    rd_chk("unmapped_0b", 6'h0B, 32'd0);

    // Write and read together: write happens, rdata zero, one ack.
    bus.reg_wr = 1'b1; bus.reg_rd = 1'b1; bus.reg_addr = 6'h00; bus.reg_wdata = 32'd3;
    @(negedge clk);
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    chk("wrrd_ack", 32'(bus.reg_ack), 32'd1);
    chk("wrrd_rdata", bus.reg_rdata, 32'd0);
    @(negedge clk);
    chk("wrrd_single_ack", 32'(bus.reg_ack), 32'd0);
    chk("wrrd_ctrl", {30'b0, dbg_stop, ring_enable}, 32'd3);

    // Ring disable clears the indices and STATUS.
    reg_write(6'h08, 32'h055);
    chk("in_prod_port", 32'(inband_prod_index), 32'h055);
    rd_chk("status_both", 6'h01, 32'd3);
    reg_write(6'h00, 32'd0);
    chk("dis_out_cons", 32'(outband_cons_index), 32'd0);
    chk("dis_in_prod", 32'(inband_prod_index), 32'd0);
    chk("dis_dbg", 32'(dbg_stop), 32'd0);
    rd_chk("dis_status", 6'h01, 32'd0);
    outband_prod_index = 12'd5;
    repeat (2) @(negedge clk);
    rd_chk("no_set_disabled", 6'h01, 32'd0);

    // Reset during a write: no ack and the write has no effect.
    rst = 1'b1;
    bus.reg_wr = 1'b1; bus.reg_addr = 6'h02; bus.reg_wdata = 32'h1111;
    @(negedge clk);
    bus.reg_wr = 1'b0;
    chk("rst_wr_ack", 32'(bus.reg_ack), 32'd0);
    chk("rst_wr_base", outband_base, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("rst_wr_base_rd", 6'h02, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
